// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared pipeline types and constants for the ID/EX stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

   localparam int CPU_WORD_W  = 32;
   localparam int CPU_REG_AW  = 5;
   localparam int CPU_ALUOP_W = 4;

   typedef logic [CPU_REG_AW-1:0]  regbits_t;
   typedef logic [CPU_WORD_W-1:0]  word_t;
   typedef logic [CPU_ALUOP_W-1:0] aluop_t;

   typedef struct packed {
      logic   valid;
      logic   RegWr;
      logic   MemRead;
      logic   MemWrite;
      logic   halt;
      aluop_t aluop;
   } idex_ctrl_t;

   // A bubble is all-zero so forwarding sees x0 with RegWr=0.
   localparam idex_ctrl_t IDEX_BUBBLE = '0;

endpackage : cpu_types_pkg

`default_nettype wire

// File: rtl/idex_wb_bypass.sv
// ============================================================================
// Module : idex_wb_bypass
// Brief  : Selects WB write data over a stale register-file read when WB
//          writes the same (non-zero) register this cycle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idex_wb_bypass
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = CPU_WORD_W,
   parameter int REG_AW = CPU_REG_AW
) (
   input  logic [REG_AW-1:0] rs,
   input  logic [WORD_W-1:0] rdat,
   input  logic              RegWr_WB,
   input  logic [REG_AW-1:0] wsel_WB,
   input  logic [WORD_W-1:0] wdat_WB,
   output logic [WORD_W-1:0] sel_dat
);

   logic w_hit;

   assign w_hit   = RegWr_WB && (wsel_WB != '0) && (wsel_WB == rs);
   assign sel_dat = w_hit ? wdat_WB : rdat;

endmodule : idex_wb_bypass

`default_nettype wire

// File: rtl/id_ex_latch.sv
// ============================================================================
// Module : id_ex_latch
// Brief  : ID/EX pipeline register with stall, flush and WB write-through.
//          Optional load-use detection enabled by macro ID_EX_LOAD_USE_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_latch
   import cpu_types_pkg::*;
#(
   parameter int WORD_W  = CPU_WORD_W,
   parameter int REG_AW  = CPU_REG_AW,
   parameter int ALUOP_W = CPU_ALUOP_W
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               en,
   input  logic               flush,
   input  logic               valid_ID,
   input  logic [REG_AW-1:0]  rs1_ID,
   input  logic [REG_AW-1:0]  rs2_ID,
   input  logic [REG_AW-1:0]  rd_ID,
   input  logic               RegWr_ID,
   input  logic               MemRead_ID,
   input  logic               MemWrite_ID,
   input  logic               halt_ID,
   input  logic [ALUOP_W-1:0] aluop_ID,
   input  logic [WORD_W-1:0]  rdat1_ID,
   input  logic [WORD_W-1:0]  rdat2_ID,
   input  logic [WORD_W-1:0]  imm_ID,
   input  logic [WORD_W-1:0]  pc_ID,
   input  logic               RegWr_WB,
   input  logic [REG_AW-1:0]  wsel_WB,
   input  logic [WORD_W-1:0]  wdat_WB,
   output logic               valid_EX,
   output logic [REG_AW-1:0]  rs1_EX,
   output logic [REG_AW-1:0]  rs2_EX,
   output logic [REG_AW-1:0]  rd_EX,
   output logic               RegWr_EX,
   output logic               MemRead_EX,
   output logic               MemWrite_EX,
   output logic               halt_EX,
   output logic [ALUOP_W-1:0] aluop_EX,
   output logic [WORD_W-1:0]  rdat1_EX,
   output logic [WORD_W-1:0]  rdat2_EX,
   output logic [WORD_W-1:0]  imm_EX,
   output logic [WORD_W-1:0]  pc_EX,
   output logic               hazard_stall
);

   idex_ctrl_t        ctrl_q,  ctrl_d;
   logic [REG_AW-1:0] rs1_q,   rs1_d;
   logic [REG_AW-1:0] rs2_q,   rs2_d;
   logic [REG_AW-1:0] rd_q,    rd_d;
   logic [WORD_W-1:0] rdat1_q, rdat1_d;
   logic [WORD_W-1:0] rdat2_q, rdat2_d;
   logic [WORD_W-1:0] imm_q,   imm_d;
   logic [WORD_W-1:0] pc_q,    pc_d;

   logic [WORD_W-1:0] w_rdat1_byp;
   logic [WORD_W-1:0] w_rdat2_byp;
   logic              w_squash;

   idex_wb_bypass #(.WORD_W(WORD_W), .REG_AW(REG_AW)) u_byp1 (
      .rs       (rs1_ID),
      .rdat     (rdat1_ID),
      .RegWr_WB (RegWr_WB),
      .wsel_WB  (wsel_WB),
      .wdat_WB  (wdat_WB),
      .sel_dat  (w_rdat1_byp)
   );

   idex_wb_bypass #(.WORD_W(WORD_W), .REG_AW(REG_AW)) u_byp2 (
      .rs       (rs2_ID),
      .rdat     (rdat2_ID),
      .RegWr_WB (RegWr_WB),
      .wsel_WB  (wsel_WB),
      .wdat_WB  (wdat_WB),
      .sel_dat  (w_rdat2_byp)
   );

`ifdef ID_EX_LOAD_USE_EN
   // Load in EX whose destination is read by ID: insert one bubble.
   assign hazard_stall = ctrl_q.valid && ctrl_q.MemRead && (rd_q != '0) &&
                         valid_ID && ((rd_q == rs1_ID) || (rd_q == rs2_ID));
`else
   assign hazard_stall = 1'b0;
`endif
   assign w_squash = hazard_stall;

   always_comb begin
      ctrl_d  = ctrl_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      rd_d    = rd_q;
      rdat1_d = rdat1_q;
      rdat2_d = rdat2_q;
      imm_d   = imm_q;
      pc_d    = pc_q;
      if (flush || (en && (w_squash || !valid_ID))) begin
         ctrl_d  = IDEX_BUBBLE;
         rs1_d   = '0;
         rs2_d   = '0;
         rd_d    = '0;
         rdat1_d = '0;
         rdat2_d = '0;
         imm_d   = '0;
         pc_d    = '0;
      end else if (en) begin
         ctrl_d.valid    = 1'b1;
         ctrl_d.RegWr    = RegWr_ID;
         ctrl_d.MemRead  = MemRead_ID;
         ctrl_d.MemWrite = MemWrite_ID;
         ctrl_d.halt     = halt_ID;
         ctrl_d.aluop    = aluop_ID;
         rs1_d           = rs1_ID;
         rs2_d           = rs2_ID;
         rd_d            = rd_ID;
         rdat1_d         = w_rdat1_byp;
         rdat2_d         = w_rdat2_byp;
         imm_d           = imm_ID;
         pc_d            = pc_ID;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ctrl_q  <= IDEX_BUBBLE;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         rdat1_q <= '0;
         rdat2_q <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         rdat1_q <= rdat1_d;
         rdat2_q <= rdat2_d;
         imm_q   <= imm_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_EX    = ctrl_q.valid;
   assign RegWr_EX    = ctrl_q.RegWr;
   assign MemRead_EX  = ctrl_q.MemRead;
   assign MemWrite_EX = ctrl_q.MemWrite;
   assign halt_EX     = ctrl_q.halt;
   assign aluop_EX    = ctrl_q.aluop;
   assign rs1_EX      = rs1_q;
   assign rs2_EX      = rs2_q;
   assign rd_EX       = rd_q;
   assign rdat1_EX    = rdat1_q;
   assign rdat2_EX    = rdat2_q;
   assign imm_EX      = imm_q;
   assign pc_EX       = pc_q;

endmodule : id_ex_latch

`default_nettype wire

// File: tb/tb_id_ex_latch.sv
// ============================================================================
// Module : tb_id_ex_latch
// Brief  : Directed self-checking bench for id_ex_latch.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_latch;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        en, flush, valid_ID;
   logic [4:0]  rs1_ID, rs2_ID, rd_ID;
   logic        RegWr_ID, MemRead_ID, MemWrite_ID, halt_ID;
   logic [3:0]  aluop_ID;
   logic [31:0] rdat1_ID, rdat2_ID, imm_ID, pc_ID;
   logic        RegWr_WB;
   logic [4:0]  wsel_WB;
   logic [31:0] wdat_WB;
   logic        valid_EX, RegWr_EX, MemRead_EX, MemWrite_EX, halt_EX;
   logic [4:0]  rs1_EX, rs2_EX, rd_EX;
   logic [3:0]  aluop_EX;
   logic [31:0] rdat1_EX, rdat2_EX, imm_EX, pc_EX;
   logic        hazard_stall;

   int checks = 0;
   int errors = 0;

   id_ex_latch dut (
      .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .valid_ID(valid_ID),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
      .RegWr_ID(RegWr_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
      .halt_ID(halt_ID), .aluop_ID(aluop_ID),
      .rdat1_ID(rdat1_ID), .rdat2_ID(rdat2_ID), .imm_ID(imm_ID), .pc_ID(pc_ID),
      .RegWr_WB(RegWr_WB), .wsel_WB(wsel_WB), .wdat_WB(wdat_WB),
      .valid_EX(valid_EX), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX),
      .RegWr_EX(RegWr_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
      .halt_EX(halt_EX), .aluop_EX(aluop_EX),
      .rdat1_EX(rdat1_EX), .rdat2_EX(rdat2_EX), .imm_EX(imm_EX), .pc_EX(pc_EX),
      .hazard_stall(hazard_stall)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic [31:0] d1, input logic [31:0] d2);
      valid_ID = 1'b1; rs1_ID = rs1; rs2_ID = rs2; rd_ID = rd;
      RegWr_ID = rw; MemRead_ID = mr; MemWrite_ID = 1'b0; halt_ID = 1'b0;
      aluop_ID = 4'd2; rdat1_ID = d1; rdat2_ID = d2;
      imm_ID = 32'h0000_0040; pc_ID = 32'h0000_1000;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      en = 1'b0; flush = 1'b0; RegWr_WB = 1'b0; wsel_WB = '0; wdat_WB = '0;
      set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      checks++;
      if ({valid_EX, rd_EX, rs1_EX, rs2_EX, RegWr_EX, MemRead_EX} !== '0) begin
         errors++; $display("FAIL reset_ctrl got %b expected 0",
                            {valid_EX, rd_EX, rs1_EX, rs2_EX, RegWr_EX, MemRead_EX});
      end
      checks++;
      if (hazard_stall !== 1'b0) begin
         errors++; $display("FAIL reset_hazard got %b expected 0", hazard_stall);
      end
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic test_capture();
      en = 1'b1;
      set_id(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 32'h11, 32'h22);
      tick();
      checks++;
      if (rs1_EX !== 5'd3) begin errors++; $display("FAIL cap_rs1 got %0d expected 3", rs1_EX); end
      checks++;
      if (rs2_EX !== 5'd4) begin errors++; $display("FAIL cap_rs2 got %0d expected 4", rs2_EX); end
      checks++;
      if (rd_EX !== 5'd5) begin errors++; $display("FAIL cap_rd got %0d expected 5", rd_EX); end
      checks++;
      if (rdat1_EX !== 32'h11) begin errors++; $display("FAIL cap_rdat1 got %h expected 11", rdat1_EX); end
      checks++;
      if (rdat2_EX !== 32'h22) begin errors++; $display("FAIL cap_rdat2 got %h expected 22", rdat2_EX); end
      checks++;
      if ({valid_EX, RegWr_EX, MemRead_EX, aluop_EX} !== {1'b1, 1'b1, 1'b0, 4'd2}) begin
         errors++; $display("FAIL cap_ctrl got %b expected 1102", {valid_EX, RegWr_EX, MemRead_EX, aluop_EX});
      end
      checks++;
      if ({imm_EX, pc_EX} !== {32'h40, 32'h1000}) begin
         errors++; $display("FAIL cap_imm_pc got %h/%h expected 40/1000", imm_EX, pc_EX);
      end
   endtask

   task automatic test_hold_flush();
      en = 1'b0;
      set_id(5'd7, 5'd8, 5'd9, 1'b0, 1'b1, 32'hDEAD, 32'hBEEF);
      RegWr_WB = 1'b1; wsel_WB = 5'd7; wdat_WB = 32'h5555;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({valid_EX, rd_EX, rdat1_EX, MemRead_EX} !== {1'b1, 5'd5, 32'h11, 1'b0}) begin
            errors++; $display("FAIL hold_%0d got rd=%0d rdat1=%h expected rd=5 rdat1=11", i, rd_EX, rdat1_EX);
         end
      end
      RegWr_WB = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if ({valid_EX, rd_EX, rs1_EX, RegWr_EX, rdat1_EX, pc_EX} !== '0) begin
         errors++; $display("FAIL flush_bubble got valid=%b rd=%0d rdat1=%h expected 0", valid_EX, rd_EX, rdat1_EX);
      end
      // flush wins over en
      en = 1'b1; flush = 1'b1;
      set_id(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 32'h11, 32'h22);
      tick();
      flush = 1'b0;
      checks++;
      if ({valid_EX, rd_EX, RegWr_EX} !== '0) begin
         errors++; $display("FAIL flush_over_en got valid=%b rd=%0d expected 0", valid_EX, rd_EX);
      end
   endtask

   task automatic test_bypass();
      en = 1'b1;
      set_id(5'd7, 5'd7, 5'd1, 1'b1, 1'b0, 32'hAAAA, 32'hBBBB);
      RegWr_WB = 1'b1; wsel_WB = 5'd7; wdat_WB = 32'h1234;
      tick();
      checks++;
      if (rdat1_EX !== 32'h1234) begin errors++; $display("FAIL byp_rs1 got %h expected 1234", rdat1_EX); end
      checks++;
      if (rdat2_EX !== 32'h1234) begin errors++; $display("FAIL byp_rs2 got %h expected 1234", rdat2_EX); end
      set_id(5'd7, 5'd6, 5'd1, 1'b1, 1'b0, 32'hAAAA, 32'hBBBB);
      wsel_WB = 5'd6;
      tick();
      checks++;
      if ({rdat1_EX, rdat2_EX} !== {32'hAAAA, 32'h1234}) begin
         errors++; $display("FAIL byp_rs2_only got %h/%h expected AAAA/1234", rdat1_EX, rdat2_EX);
      end
      set_id(5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 32'hAAAA, 32'hBBBB);
      wsel_WB = 5'd0;
      tick();
      checks++;
      if ({rdat1_EX, rdat2_EX} !== {32'hAAAA, 32'hBBBB}) begin
         errors++; $display("FAIL byp_x0 got %h/%h expected AAAA/BBBB", rdat1_EX, rdat2_EX);
      end
      set_id(5'd7, 5'd7, 5'd1, 1'b1, 1'b0, 32'hAAAA, 32'hBBBB);
      RegWr_WB = 1'b0; wsel_WB = 5'd7;
      tick();
      checks++;
      if (rdat1_EX !== 32'hAAAA) begin errors++; $display("FAIL byp_nowr got %h expected AAAA", rdat1_EX); end
   endtask

   task automatic test_invalid();
      en = 1'b1;
      set_id(5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 32'h77, 32'h88);
      valid_ID = 1'b0;
      tick();
      checks++;
      if ({valid_EX, RegWr_EX, MemRead_EX, MemWrite_EX, halt_EX} !== 5'b0) begin
         errors++; $display("FAIL invalid_ctrl got %b expected 00000",
                            {valid_EX, RegWr_EX, MemRead_EX, MemWrite_EX, halt_EX});
      end
   endtask

   task automatic test_load_use();
      en = 1'b1;
      set_id(5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 32'h0, 32'h0);
      tick();
      set_id(5'd3, 5'd9, 5'd10, 1'b1, 1'b0, 32'h33, 32'h99);
      #1;
`ifdef ID_EX_LOAD_USE_EN
      checks++;
      if (hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b expected 1", hazard_stall); end
      tick();
      checks++;
      if ({valid_EX, MemRead_EX, rd_EX} !== '0) begin
         errors++; $display("FAIL lu_bubble got valid=%b rd=%0d expected 0", valid_EX, rd_EX);
      end
      checks++;
      if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_clear got %b expected 0", hazard_stall); end
      tick();
`else
      checks++;
      if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_nostall got %b expected 0", hazard_stall); end
      tick();
`endif
      checks++;
      if ({valid_EX, rd_EX, rs2_EX, rdat2_EX} !== {1'b1, 5'd10, 5'd9, 32'h99}) begin
         errors++; $display("FAIL lu_capture got valid=%b rd=%0d rs2=%0d expected 1/10/9", valid_EX, rd_EX, rs2_EX);
      end
      // load with rd=x0 never stalls
      set_id(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 32'h0, 32'h0);
      tick();
      set_id(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 32'h0, 32'h0);
      #1;
      checks++;
      if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_rd0 got %b expected 0", hazard_stall); end
   endtask

   task automatic test_reset_midcycle();
      en = 1'b1;
      set_id(5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 32'h5, 32'h6);
      tick();
      set_id(5'd9, 5'd0, 5'd3, 1'b1, 1'b0, 32'h7, 32'h8);
      #2;
      nRST = 1'b0;
      #1;
      checks++;
      if ({valid_EX, rd_EX, MemRead_EX, RegWr_EX, rdat1_EX, imm_EX, pc_EX} !== '0) begin
         errors++; $display("FAIL async_reset got valid=%b rd=%0d rdat1=%h expected 0", valid_EX, rd_EX, rdat1_EX);
      end
      checks++;
      if (hazard_stall !== 1'b0) begin errors++; $display("FAIL async_reset_hz got %b expected 0", hazard_stall); end
      @(negedge CLK);
      nRST = 1'b1;
      en = 1'b0;
      tick();
      checks++;
      if (valid_EX !== 1'b0) begin errors++; $display("FAIL post_reset_hold got %b expected 0", valid_EX); end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_hold_flush();
      test_bypass();
      test_invalid();
      test_load_use();
      test_reset_midcycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_id_ex_latch

`default_nettype wire

// File: doc/id_ex_latch.md
Name: id_ex_latch

Overview:
- ID/EX pipeline register. Captures decoded instruction state from ID, presents it to EX.
- Its rs1_EX/rs2_EX outputs feed the forwarding unit; its RegWr_EX/rd_EX become EX/MEM inputs and, a cycle later, the forwarding unit's wsel_MEM.
- Supports stall (hold), flush (bubble insertion) and a WB write-through bypass that covers the register-file write/read race.

Parameters:
- WORD_W, 32, data/PC width.
- REG_AW, 5, register address width.
- ALUOP_W, 4, ALU opcode width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- en  in  1  advance latch (ihit & ~upstream stall).
- flush  in  1  squash: load a bubble.
- valid_ID  in  1  ID holds a real instruction.
- rs1_ID, rs2_ID, rd_ID  in  REG_AW each  decoded register addresses.
- RegWr_ID, MemRead_ID, MemWrite_ID, halt_ID  in  1 each  control.
- aluop_ID  in  ALUOP_W  ALU op.
- rdat1_ID, rdat2_ID, imm_ID, pc_ID  in  WORD_W each  operands/PC.
- RegWr_WB  in  1  WB write enable.
- wsel_WB  in  REG_AW  WB destination.
- wdat_WB  in  WORD_W  WB data.
- valid_EX, rs1_EX, rs2_EX, rd_EX, RegWr_EX, MemRead_EX, MemWrite_EX, halt_EX, aluop_EX, rdat1_EX, rdat2_EX, imm_EX, pc_EX  out  same widths as _ID counterparts  registered EX-stage copies.
- hazard_stall  out  1  load-use stall request to IF/ID and PC.

Behaviour:
- Reset (nRST=0, async): every output register = 0, i.e. a bubble. hazard_stall = 0.
- Latency: 1 cycle. Fields sampled at a rising edge appear on _EX outputs after that edge.
- Bubble = valid, all control, register addresses, aluop and data = 0. Forwarding sees x0 and RegWr=0, so it never forwards from a bubble.
- Edge priority, highest first:
  - flush=1: load bubble, regardless of en.
  - en=1 and squash_int=1: load bubble.
  - en=1: capture the ID fields.
  - en=0: hold all outputs.
- valid_ID=0 with en=1: capture as a bubble (valid_EX=0, controls forced 0).
- WB bypass on capture only:
  - if RegWr_WB && wsel_WB!=0 && wsel_WB==rs1_ID, rdat1_EX <= wdat_WB, else rdat1_ID.
  - Same rule for rs2 → rdat2_EX.
  - Both may bypass in the same edge.
  - wsel_WB=0 never bypasses.
  - The bypass is ignored on hold and on flush.
- squash_int = hazard_stall when the feature is compiled in, else 0.
- Reset asserted mid-stall or mid-flush: outputs go to bubble immediately; no pending state survives.
- No width conversion: all fields are passed through unchanged.

Optional Feature:
- Macro: ID_EX_LOAD_USE_EN.
- Defined:
  - hazard_stall = valid_EX && MemRead_EX && rd_EX!=0 && valid_ID && (rd_EX==rs1_ID || rd_EX==rs2_ID). Combinational from registered state plus ID inputs.
  - While hazard_stall=1 and en=1, the latch loads a bubble. Upstream must hold PC and IF/ID.
  - After one bubble, MemRead_EX=0, so the stall self-clears the next cycle.
- Undefined: hazard_stall tied 0. An external hazard unit drives flush/en.

Decomposition:
- In cpu_types_pkg:
  - regbits_t, word_t, aluop_t.
  - idex_ctrl_t packed struct {valid, RegWr, MemRead, MemWrite, halt, aluop}.
  - Constant IDEX_BUBBLE of type idex_ctrl_t.
- Sub-module idex_wb_bypass: combinational, one instance per operand. Inputs rs, rdat, RegWr_WB, wsel_WB, wdat_WB; output selected word.
- Latch register body lives in id_ex_latch.

Test Plan:
- Reset then release: assert nRST=0 mid-cycle → all _EX=0 asynchronously; hazard_stall=0.
- Capture: en=1, valid_ID=1, rs1=3, rs2=4, rd=5, RegWr=1, rdat1=0x11, aluop=2 → next cycle rs1_EX=3, rd_EX=5, rdat1_EX=0x11, valid_EX=1.
- Hold and flush: en=0 for 3 cycles → outputs unchanged; flush=1 with en=0 → bubble next edge.
- WB bypass: rs1_ID=7, rdat1_ID=0xAAAA, RegWr_WB=1, wsel_WB=7, wdat_WB=0x1234 → rdat1_EX=0x1234. Repeat with wsel_WB=0 → rdat1_EX=0xAAAA.
- Load-use (macro on): EX holds MemRead=1, rd=9; ID has rs2=9, en=1 → hazard_stall=1 and bubble latched. The next cycle hazard_stall=0, and the held instruction is captured on the following edge.
- Macro off, same stimulus: hazard_stall stays 0 and the ID instruction is captured directly.
